// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: register file, EX/MEM and WB forwarding, load-use
// hazard detection and the pipeline register that feeds the ALU.
module id_ex_operand_stage #(
   parameter  int DATA_W = 32,
   parameter  int NREGS  = 32,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [AW-1:0]     id_rs,
   input  logic [AW-1:0]     id_rt,
   input  logic [AW-1:0]     id_rd,
   input  logic              id_uses_rt,
   input  logic [15:0]       id_imm,
   input  logic              id_alu_src,
   input  logic [3:0]        id_op,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              flush,
   input  logic              exmem_reg_write,
   input  logic [AW-1:0]     exmem_rd,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              wb_en,
   input  logic [AW-1:0]     wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] Reg1,
   output logic [DATA_W-1:0] Reg2,
   output logic [3:0]        op,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [AW-1:0]     ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_valid,
   output logic              stall
);

   logic [DATA_W-1:0] r_rf [NREGS];
   logic [DATA_W-1:0] w_rs_val;
   logic [DATA_W-1:0] w_rt_val;
   logic [DATA_W-1:0] w_imm32;
   logic              w_hazard;
   logic              w_bubble;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
      end else if (wb_en && (wb_addr != '0)) begin
         r_rf[wb_addr] <= wb_data;
      end
   end

   // EX/MEM is younger than WB, so it is checked first.
   always_comb begin
      w_rs_val = r_rf[id_rs];
      if (id_rs == '0)
         w_rs_val = '0;
      else if (exmem_reg_write && (exmem_rd == id_rs))
         w_rs_val = exmem_result;
      else if (wb_en && (wb_addr == id_rs))
         w_rs_val = wb_data;
   end

   always_comb begin
      w_rt_val = r_rf[id_rt];
      if (id_rt == '0)
         w_rt_val = '0;
      else if (exmem_reg_write && (exmem_rd == id_rt))
         w_rt_val = exmem_result;
      else if (wb_en && (wb_addr == id_rt))
         w_rt_val = wb_data;
   end

   assign w_imm32  = {{(DATA_W-16){id_imm[15]}}, id_imm};
   assign w_hazard = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
   assign w_bubble = flush || w_hazard;
   assign stall    = w_hazard && !flush;

   // A bubble clears the datapath too, so the ALU produces a fixed 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Reg1          <= '0;
         Reg2          <= '0;
         op            <= '0;
         ex_store_data <= '0;
         ex_rd         <= '0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_valid      <= 1'b0;
      end else if (w_bubble) begin
         Reg1          <= '0;
         Reg2          <= '0;
         op            <= '0;
         ex_store_data <= '0;
         ex_rd         <= '0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_valid      <= 1'b0;
      end else begin
         Reg1          <= w_rs_val;
         Reg2          <= id_alu_src ? w_imm32 : w_rt_val;
         op            <= id_op;
         ex_store_data <= w_rt_val;
         ex_rd         <= id_rd;
         ex_reg_write  <= id_valid && id_reg_write;
         ex_mem_read   <= id_valid && id_mem_read;
         ex_mem_write  <= id_valid && id_mem_write;
         ex_valid      <= id_valid;
      end
   end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios plus random traffic
// checked against a behavioural model of the operand stage.
module tb_id_ex_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_uses_rt, id_alu_src, id_reg_write, id_mem_read, id_mem_write;
   logic [4:0]  id_rs, id_rt, id_rd, exmem_rd, wb_addr;
   logic [15:0] id_imm;
   logic [3:0]  id_op;
   logic        flush, exmem_reg_write, wb_en;
   logic [31:0] exmem_result, wb_data;
   logic [31:0] Reg1, Reg2, ex_store_data;
   logic [3:0]  op;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_valid, stall;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_rf [32];
   logic [31:0] m_reg1, m_reg2, m_store;
   logic [3:0]  m_op;
   logic [4:0]  m_rd;
   logic        m_rw, m_mr, m_mw, m_valid;

   id_ex_operand_stage dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_uses_rt(id_uses_rt), .id_imm(id_imm), .id_alu_src(id_alu_src),
      .id_op(id_op), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .flush(flush),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
      .exmem_result(exmem_result), .wb_en(wb_en), .wb_addr(wb_addr),
      .wb_data(wb_data), .Reg1(Reg1), .Reg2(Reg2), .op(op),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_valid(ex_valid), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_reg1 = '0; m_reg2 = '0; m_store = '0; m_op = '0; m_rd = '0;
      m_rw = 0; m_mr = 0; m_mw = 0; m_valid = 0;
   endtask

   task automatic check_all();
      check("Reg1", Reg1, m_reg1);
      check("Reg2", Reg2, m_reg2);
      check("op", {28'd0, op}, {28'd0, m_op});
      check("store", ex_store_data, m_store);
      check("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
      check("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m_rw});
      check("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m_mr});
      check("ex_mem_write", {31'd0, ex_mem_write}, {31'd0, m_mw});
      check("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
   endtask

   function automatic logic [31:0] resolve(input logic [4:0] a);
      if (a == 0) return 32'd0;
      if (exmem_reg_write && exmem_rd == a) return exmem_result;
      if (wb_en && wb_addr == a) return wb_data;
      return m_rf[a];
   endfunction

   task automatic idle();
      id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0;
      id_imm = 0; id_alu_src = 0; id_op = 0; id_reg_write = 0;
      id_mem_read = 0; id_mem_write = 0; flush = 0;
      exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
      wb_en = 0; wb_addr = 0; wb_data = 0;
   endtask

   // Called just after a negedge with inputs already driven; returns at the next negedge.
   task automatic step();
      logic [31:0] a, b;
      logic        hz;
      #1;
      hz = id_valid && m_valid && m_mr && (m_rd != 0) &&
           (m_rd == id_rs || (id_uses_rt && m_rd == id_rt));
      check("stall", {31'd0, stall}, {31'd0, hz && !flush});
      a = resolve(id_rs);
      b = resolve(id_rt);
      @(posedge clk);
      if (flush || hz) begin
         m_reg1 = 0; m_reg2 = 0; m_store = 0; m_op = 0; m_rd = 0;
         m_rw = 0; m_mr = 0; m_mw = 0; m_valid = 0;
      end else begin
         m_reg1  = a;
         m_reg2  = id_alu_src ? 32'($signed(id_imm)) : b;
         m_store = b;
         m_op    = id_op;
         m_rd    = id_rd;
         m_valid = id_valid;
         m_rw    = id_valid && id_reg_write;
         m_mr    = id_valid && id_mem_read;
         m_mw    = id_valid && id_mem_write;
      end
      if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
      #1;
      check_all();
      @(negedge clk);
   endtask

   task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
      idle(); wb_en = 1; wb_addr = addr; wb_data = data;
      step();
   endtask

   initial begin
      idle();
      rst_n = 0;
      model_reset();
      #12;
      check_all();
      check("rst_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      rst_n = 1;

      // basic path
      wb_write(5'd3, 32'd3);
      wb_write(5'd2, 32'd2);
      idle(); id_valid = 1; id_rs = 3; id_rt = 2; id_op = 4'b0010; id_reg_write = 1; id_rd = 7;
      step();
      check("basic_reg1", Reg1, 32'd3);
      check("basic_reg2", Reg2, 32'd2);
      check("basic_valid", {31'd0, ex_valid}, 32'd1);

      // forwarding priority, then WB bypass alone
      wb_write(5'd3, 32'd1);
      idle(); id_valid = 1; id_rs = 3; wb_en = 1; wb_addr = 3; wb_data = 5;
      exmem_reg_write = 1; exmem_rd = 3; exmem_result = 7;
      step();
      check("fwd_exmem", Reg1, 32'd7);
      wb_write(5'd3, 32'd1);
      idle(); id_valid = 1; id_rs = 3; wb_en = 1; wb_addr = 3; wb_data = 5;
      step();
      check("fwd_wb", Reg1, 32'd5);

      // load-use: one stall cycle, then issue
      wb_write(5'd4, 32'h44);
      idle(); id_valid = 1; id_rd = 4; id_mem_read = 1; id_reg_write = 1; id_rs = 3;
      step();
      idle(); id_valid = 1; id_rs = 4; id_op = 4'b0110; id_reg_write = 1; id_rd = 9;
      #1 check("lu_stall", {31'd0, stall}, 32'd1);
      step();
      check("lu_bubble_op", {28'd0, op}, 32'd0);
      check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
      step();
      check("lu_issue_op", {28'd0, op}, 32'd6);
      check("lu_issue_reg1", Reg1, 32'h44);

      // zero register
      idle(); id_valid = 1; id_rs = 0; wb_en = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF;
      exmem_reg_write = 1; exmem_rd = 0; exmem_result = 9;
      step();
      check("zero_reg1", Reg1, 32'd0);

      // immediate, then flush together with a hazard
      idle(); id_valid = 1; id_alu_src = 1; id_imm = 16'hFFFE; id_rt = 2;
      step();
      check("imm_reg2", Reg2, 32'hFFFFFFFE);
      check("imm_store", ex_store_data, 32'd2);
      idle(); id_valid = 1; id_rd = 6; id_mem_read = 1; id_reg_write = 1;
      step();
      idle(); id_valid = 1; id_rs = 6; id_op = 4'b0001; flush = 1;
      #1 check("flush_stall", {31'd0, stall}, 32'd0);
      step();
      check("flush_valid", {31'd0, ex_valid}, 32'd0);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         id_valid        = ($urandom_range(0, 3) != 0);
         id_rs           = 5'($urandom_range(0, 7));
         id_rt           = 5'($urandom_range(0, 7));
         id_rd           = 5'($urandom_range(0, 7));
         id_uses_rt      = 1'($urandom_range(0, 1));
         id_imm          = 16'($urandom);
         id_alu_src      = 1'($urandom_range(0, 1));
         id_op           = 4'($urandom);
         id_reg_write    = 1'($urandom_range(0, 1));
         id_mem_read     = ($urandom_range(0, 2) == 0);
         id_mem_write    = ($urandom_range(0, 3) == 0);
         flush           = ($urandom_range(0, 9) == 0);
         exmem_reg_write = 1'($urandom_range(0, 1));
         exmem_rd        = 5'($urandom_range(0, 7));
         exmem_result    = $urandom;
         wb_en           = ($urandom_range(0, 2) != 0);
         wb_addr         = 5'($urandom_range(0, 7));
         wb_data         = $urandom;
         step();
      end

      // asynchronous reset in the middle of a stall
      idle(); id_valid = 1; id_rd = 4; id_mem_read = 1; id_reg_write = 1;
      step();
      idle(); id_valid = 1; id_rs = 4;
      #1 check("rst_pre_stall", {31'd0, stall}, 32'd1);
      #2 rst_n = 0;
      #1;
      model_reset();
      check_all();
      check("rst_mid_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      rst_n = 1;
      idle(); id_valid = 1; id_rs = 5;
      step();
      check("rst_r5", Reg1, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Pipeline stage directly upstream of the ALU: register file, operand forwarding, load-use hazard detection and the ID/EX pipeline register.
- Drives the ALU's Reg1, Reg2 and op inputs from registered outputs, plus destination/control for later stages.
- Decoded fields come from ID; write-back and EX/MEM results come back from downstream.

Parameters:
- DATA_W, 32, datapath width.
- NREGS, 32, architectural registers; address width is log2(NREGS) = 5.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  5  source register 1.
- id_rt  in  5  source register 2.
- id_rd  in  5  destination register, already muxed by the decoder.
- id_uses_rt  in  1  instruction reads rt; used for the hazard check.
- id_imm  in  16  immediate, sign-extended here.
- id_alu_src  in  1  1 = Reg2 takes the immediate.
- id_op  in  4  ALU operation code.
- id_reg_write  in  1  instruction writes id_rd.
- id_mem_read  in  1  instruction is a load.
- id_mem_write  in  1  instruction is a store.
- flush  in  1  squash the instruction entering EX.
- exmem_reg_write  in  1  EX/MEM stage will write.
- exmem_rd  in  5  EX/MEM destination.
- exmem_result  in  32  EX/MEM ALU result.
- wb_en  in  1  write-back enable.
- wb_addr  in  5  write-back register.
- wb_data  in  32  write-back data.
- Reg1  out  32  ALU operand A, registered.
- Reg2  out  32  ALU operand B, registered.
- op  out  4  ALU operation, registered.
- ex_store_data  out  32  forwarded rt value, registered.
- ex_rd  out  5  registered destination.
- ex_reg_write  out  1  registered write enable.
- ex_mem_read  out  1  registered load flag.
- ex_mem_write  out  1  registered store flag.
- ex_valid  out  1  EX holds a real instruction.
- stall  out  1  combinational; ID/IF must hold.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-stall):
  - All registered outputs are 0; op = 4'b0000.
  - All NREGS register-file entries are 0.
  - Takes effect immediately, without waiting for a clock edge.
- Register file:
  - Write at posedge when wb_en && wb_addr != 0.
  - Register 0 always reads 0; writes to it are discarded.
  - Reads are combinational.
- Operand resolution, per source, priority high to low:
  1. Address is 0 -> 0.
  2. exmem_reg_write && exmem_rd == addr -> exmem_result.
  3. wb_en && wb_addr == addr -> wb_data (same-cycle write bypass).
  4. Register-file contents.
- Immediate: imm32 = {{16{id_imm[15]}}, id_imm}.
- Reg2 next value:
  - alu_src = 1 -> imm32.
  - alu_src = 0 -> resolved rt.
  - ex_store_data always takes the resolved rt value.
- Load-use hazard = id_valid && ex_valid && ex_mem_read && ex_rd != 0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt)).
- stall = hazard && !flush.
- Each posedge selects exactly one case:
  - Normal (no flush, no hazard): capture all ID fields, resolved operands and ex_valid = id_valid. Latency is 1 cycle from ID to the ALU inputs.
  - Bubble (flush or hazard): ex_valid = 0, ex_reg_write = 0, ex_mem_read = 0, ex_mem_write = 0, op = 0000. Reg1, Reg2, ex_store_data and ex_rd are also cleared to 0, giving a deterministic ALU result of 0.
  - Hazard without flush: the ID instruction is not consumed. On the next cycle ex_mem_read of the bubble is 0, so the stall lasts exactly 1 cycle. The load result then reaches EX/MEM for forwarding.
- id_valid = 0 with no flush: fields are captured but ex_valid = 0 and ex_reg_write, ex_mem_read and ex_mem_write are forced to 0.
- Flush and hazard together: flush wins; bubble inserted, stall = 0.
- Simultaneous WB and EX/MEM hits on the same register: EX/MEM wins, since it is the younger value.

Test Plan:
- Reset: rst_n = 0 asserted between clock edges during a stall -> outputs 0 immediately, stall = 0; after release, reading rs = 5 gives Reg1 = 0.
- Basic path: write r3 = 3 and r2 = 2 via WB; then id rs = 3, rt = 2, op = 0010, alu_src = 0 -> next cycle Reg1 = 3, Reg2 = 2, op = 0010, ex_valid = 1.
- Forwarding priority: r3 = 1 in file; in one cycle wb writes r3 = 5 and exmem_rd = 3 with exmem_result = 7; id rs = 3 -> Reg1 = 7. Repeat without EX/MEM -> Reg1 = 5 (bypass).
- Load-use: EX holds lw r4 (ex_mem_read = 1); id rs = 4 -> stall = 1 for 1 cycle, bubble with op = 0000 and ex_valid = 0. Next edge: instruction issues and stall = 0.
- Zero register: wb writes r0 = FFFFFFFF; exmem_rd = 0 with exmem_result = 9; id rs = 0 -> Reg1 = 0.
- Immediate and flush: id_alu_src = 1, id_imm = FFFE -> Reg2 = FFFFFFFE. Then hazard plus flush in the same cycle -> bubble, stall = 0.
